// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. It captures the register-file operands, with
// same-cycle write-back bypass, and the decoded control for the ID
// instruction. It detects load-use hazards against the instruction already
// in EX and loads a bubble on a hazard or a branch flush.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic              id_use_src2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_val,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic [3:0]        ex_exe_cmd
);

    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic              hazard;

    // Operand select: r0 reads as zero, and a same-cycle WB write wins over the
    // stale register-file read.
    always_comb begin
        val1 = reg1;
        val2 = reg2;
        if (src1 == '0)
            val1 = '0;
        else if (wb_en && (wb_dest == src1))
            val1 = wb_val;
        if (src2 == '0)
            val2 = '0;
        else if (wb_en && (wb_dest == src2))
            val2 = wb_val;
    end

    // Load-use detection against the instruction in EX. WB is not involved,
    // so the stall path stays short.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_valid && ex_mem_r_en && (ex_dest != '0))
            hazard = (ex_dest == src1) || (id_use_src2 && (ex_dest == src2));
    end

    // A flushed instruction dies anyway, so it must not hold the front end.
    assign hazard_stall = hazard && !flush;

    // Stage register. Freeze holds everything. Flush or hazard loads a bubble.
    // Otherwise the ID payload is loaded, with control gated by id_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_imm      <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_dest     <= '0;
            ex_wb_en    <= 1'b0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_exe_cmd  <= '0;
        end else if (!freeze) begin
            if (flush || hazard) begin
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_val1     <= '0;
                ex_val2     <= '0;
                ex_imm      <= '0;
                ex_src1     <= '0;
                ex_src2     <= '0;
                ex_dest     <= '0;
                ex_wb_en    <= 1'b0;
                ex_mem_r_en <= 1'b0;
                ex_mem_w_en <= 1'b0;
                ex_exe_cmd  <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                ex_val1     <= val1;
                ex_val2     <= val2;
                ex_imm      <= id_imm;
                ex_src1     <= src1;
                ex_src2     <= src2;
                ex_dest     <= id_dest;
                ex_wb_en    <= id_valid && id_wb_en;
                ex_mem_r_en <= id_valid && id_mem_r_en;
                ex_mem_w_en <= id_valid && id_mem_w_en;
                ex_exe_cmd  <= id_exe_cmd;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboarded bench for id_ex_stage_reg: a driver issues stimulus at the
// falling edge and pushes the reference model's expectation, and a monitor
// pops it and compares hazard_stall before the edge and ex_* after it.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze, flush, id_valid, id_use_src2;
    logic [31:0] id_pc, reg1, reg2, id_imm, wb_val;
    logic [4:0]  src1, src2, id_dest, wb_dest;
    logic        id_wb_en, id_mem_r_en, id_mem_w_en, wb_en;
    logic [3:0]  id_exe_cmd;
    logic        hazard_stall, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en;
    logic [31:0] ex_pc, ex_val1, ex_val2, ex_imm;
    logic [4:0]  ex_src1, ex_src2, ex_dest;
    logic [3:0]  ex_exe_cmd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  s1, s2, dest;
        logic        wb, mr, mw;
        logic [3:0]  cmd;
    } ex_t;

    typedef struct {
        logic hs;
        ex_t  ex;
    } exp_t;

    ex_t  m;
    exp_t sb[$];

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .src1(src1), .src2(src2),
        .reg1(reg1), .reg2(reg2), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_exe_cmd(id_exe_cmd), .id_imm(id_imm),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_exe_cmd(ex_exe_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The value an instruction should see for a source register.
    function automatic logic [31:0] operand(input logic [4:0] s, input logic [31:0] r);
        if (s == 0) return 32'd0;
        if (wb_en && wb_dest == s) return wb_val;
        return r;
    endfunction

    // Reference model: derive the expectation from the current inputs and
    // the model's view of EX, then queue it for the monitor.
    task automatic push();
        exp_t e;
        logic haz;
        haz = id_valid && m.valid && m.mr && (m.dest != 0) &&
              ((m.dest == src1) || (id_use_src2 && (m.dest == src2)));
        e.hs = haz && !flush;
        if (!freeze) begin
            if (flush || haz) begin
                m = '{default: '0};
            end else begin
                m.valid = id_valid;
                m.pc    = id_pc;
                m.v1    = operand(src1, reg1);
                m.v2    = operand(src2, reg2);
                m.imm   = id_imm;
                m.s1    = src1;
                m.s2    = src2;
                m.dest  = id_dest;
                m.wb    = id_valid && id_wb_en;
                m.mr    = id_valid && id_mem_r_en;
                m.mw    = id_valid && id_mem_w_en;
                m.cmd   = id_exe_cmd;
            end
        end
        e.ex = m;
        sb.push_back(e);
    endtask

    task automatic clear_in();
        freeze = 0; flush = 0; id_valid = 0; id_use_src2 = 0;
        id_pc = 0; reg1 = 0; reg2 = 0; id_imm = 0; wb_val = 0;
        src1 = 0; src2 = 0; id_dest = 0; wb_dest = 0;
        id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; wb_en = 0; id_exe_cmd = 0;
    endtask

    task automatic rand_in();
        id_valid    = ($urandom_range(0, 9) < 8);
        id_pc       = $urandom;
        src1        = 5'($urandom_range(0, 7));
        src2        = 5'($urandom_range(0, 7));
        reg1        = $urandom;
        reg2        = $urandom;
        id_use_src2 = 1'($urandom);
        id_dest     = 5'($urandom_range(0, 7));
        id_wb_en    = 1'($urandom);
        id_mem_r_en = ($urandom_range(0, 9) < 3);
        id_mem_w_en = 1'($urandom);
        id_exe_cmd  = id_valid ? 4'($urandom) : 4'd0;
        id_imm      = $urandom;
        wb_en       = 1'($urandom);
        wb_dest     = 5'($urandom_range(0, 7));
        wb_val      = $urandom;
        flush       = ($urandom_range(0, 9) == 0);
        freeze      = ($urandom_range(0, 9) == 0);
    endtask

    // Start a cycle: wait for the falling edge and clear all inputs.
    task automatic cyc();
        @(negedge clk);
        clear_in();
    endtask

    // Monitor: hazard_stall is sampled while the inputs are settled before
    // the edge, and the registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hazard_stall", 32'(hazard_stall), 32'(e.hs));
                @(posedge clk);
                #1;
                chk("ex_valid", 32'(ex_valid), 32'(e.ex.valid));
                chk("ex_pc", ex_pc, e.ex.pc);
                chk("ex_val1", ex_val1, e.ex.v1);
                chk("ex_val2", ex_val2, e.ex.v2);
                chk("ex_imm", ex_imm, e.ex.imm);
                chk("ex_src1", 32'(ex_src1), 32'(e.ex.s1));
                chk("ex_src2", 32'(ex_src2), 32'(e.ex.s2));
                chk("ex_dest", 32'(ex_dest), 32'(e.ex.dest));
                chk("ex_wb_en", 32'(ex_wb_en), 32'(e.ex.wb));
                chk("ex_mem_r_en", 32'(ex_mem_r_en), 32'(e.ex.mr));
                chk("ex_mem_w_en", 32'(ex_mem_w_en), 32'(e.ex.mw));
                chk("ex_exe_cmd", 32'(ex_exe_cmd), 32'(e.ex.cmd));
            end
        end
    end

    // Load to r7 sitting in ID: mem read, write-back, destination 7.
    task automatic load_r7();
        id_valid = 1; id_mem_r_en = 1; id_wb_en = 1; id_dest = 7; id_pc = 32'h100;
    endtask

    initial begin
        int guard;
        m = '{default: '0};
        clear_in();
        // Reset with arbitrary inputs: everything stays at zero.
        rst = 0;
        rand_in();
        freeze = 0;
        #1;
        chk("rst ex_valid", 32'(ex_valid), 0);
        chk("rst ex_pc", ex_pc, 0);
        chk("rst hazard_stall", 32'(hazard_stall), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst ex_val1", ex_val1, 0);
        chk("rst ex_dest", 32'(ex_dest), 0);
        chk("rst ex_mem_r_en", 32'(ex_mem_r_en), 0);

        // First real instruction after release.
        cyc(); rst = 1; id_valid = 1; src1 = 3; reg1 = 32'h11; push();

        // WB bypass beats the register-file read, but not for r0.
        cyc(); id_valid = 1; src1 = 5; reg1 = 32'hAAAA;
        wb_en = 1; wb_dest = 5; wb_val = 32'h1234; push();
        cyc(); id_valid = 1; src1 = 0; reg1 = 32'hAAAA;
        wb_en = 1; wb_dest = 0; wb_val = 32'h1234; push();

        // Load-use on src2: one bubble, then the instruction advances.
        cyc(); load_r7(); push();
        repeat (2) begin
            cyc(); id_valid = 1; src2 = 7; reg2 = 32'h77; id_use_src2 = 1;
            id_exe_cmd = 4'd3; push();
        end
        // Same reader without src2 use: no stall.
        cyc(); load_r7(); push();
        cyc(); id_valid = 1; src2 = 7; reg2 = 32'h77; id_use_src2 = 0; push();

        // Flush kills a valid instruction; flush masks a pending hazard.
        cyc(); id_valid = 1; id_wb_en = 1; id_mem_w_en = 1; id_exe_cmd = 4'd9;
        id_dest = 4; flush = 1; push();
        cyc(); load_r7(); push();
        cyc(); id_valid = 1; src1 = 7; flush = 1; push();

        // Freeze for 3 cycles with changing ID inputs and a flush pulse.
        cyc(); id_valid = 1; id_pc = 32'h200; src1 = 2; reg1 = 32'hBEEF;
        id_dest = 3; id_wb_en = 1; push();
        for (int i = 0; i < 3; i++) begin
            cyc(); rand_in(); freeze = 1; flush = (i == 1); push();
        end
        cyc(); rand_in(); freeze = 0; flush = 0; push();

        // Asynchronous reset between edges while EX holds an instruction.
        cyc(); id_valid = 1; id_pc = 32'h300; id_dest = 6; id_wb_en = 1; push();
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk("async ex_valid", 32'(ex_valid), 0);
        chk("async ex_wb_en", 32'(ex_wb_en), 0);
        chk("async ex_pc", ex_pc, 0);
        m = '{default: '0};
        cyc(); rst = 1; push();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(); rand_in(); push();
        end

        cyc();
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, 0 expected", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the MIPS pipeline. It sits directly downstream of the register file. It captures the operands read from the register file, together with the decoded control for the instruction in ID, and presents them to EX one cycle later. It bypasses a same-cycle write-back value into the captured operands, detects load-use hazards against the instruction already in EX, and inserts bubbles on hazard or branch flush.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  downstream stall; hold all registers
- flush  in  1  branch taken in EX; kill the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC of the ID instruction
- src1, src2  in  REG_AW  register file read indices
- reg1, reg2  in  DATA_W  register file read data
- id_use_src2  in  1  instruction reads src2 (R-type, store, branch)
- id_dest  in  REG_AW  destination register
- id_wb_en, id_mem_r_en, id_mem_w_en  in  1 each  control bits
- id_exe_cmd  in  4  ALU command
- id_imm  in  DATA_W  sign-extended immediate
- wb_en  in  1  WB stage writing this cycle
- wb_dest  in  REG_AW  WB destination
- wb_val  in  DATA_W  WB value
- hazard_stall  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_val1, ex_val2, ex_imm  out  DATA_W each  registered payload
- ex_src1, ex_src2, ex_dest  out  REG_AW each  registered indices (for EX forwarding)
- ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  1 each  registered control
- ex_exe_cmd  out  4  registered ALU command

## Operation
- Operand select, per source n: if src_n == 0, the value is 0. Otherwise, if wb_en && wb_dest == src_n, the value is wb_val. Otherwise it is reg_n.
- hazard = id_valid && ex_valid && ex_mem_r_en && ex_dest != 0 && (ex_dest == src1 || (id_use_src2 && ex_dest == src2)).
- hazard_stall = hazard && !flush. A flushed instruction needs no stall.
- Update priority on each rising edge:
  1. freeze: every register holds. flush and hazard are ignored; the sources keep them asserted until freeze drops.
  2. flush: load a bubble.
  3. hazard: load a bubble. Upstream holds ID, so the same instruction re-presents next cycle.
  4. otherwise: load the ID payload, with ex_valid = id_valid.
- Bubble contents: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en = 0; ex_exe_cmd = 0; ex_dest, ex_src1, ex_src2 = 0. Data fields are don't-care but are loaded as 0.
- Input gating: if id_valid = 0, the control bits are still loaded as 0 regardless of the id_* inputs.
- No state machine. State is the valid bit plus the payload registers.

## Timing
- Reset (rst low, asynchronous): every output register is 0 immediately and stays 0 until the first rising edge after rst goes high. hazard_stall is then 0 because ex_valid = 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- hazard_stall has combinational paths from src1/src2/id_valid/id_use_src2/flush and from the ex_* registers. It must not depend on wb_*.
- A load-use hazard costs exactly one bubble. On the next cycle ex_mem_r_en = 0, so hazard deasserts and the instruction advances, with its operand taken from EX/MEM forwarding (outside this block).
- Simultaneous wb write and ID read of the same register: wb_val is captured, never the stale reg_n.
- rst asserted mid-freeze or mid-hazard: reset wins and the pipeline restarts empty.

## Test plan
- Reset: drive rst=0 with arbitrary inputs, then release. All ex_* = 0 and hazard_stall = 0. The first edge with id_valid=1, src1=3, reg1=0x11 gives ex_val1=0x11, ex_valid=1.
- Bypass: src1=5, reg1=0xAAAA, wb_en=1, wb_dest=5, wb_val=0x1234 gives ex_val1=0x1234 next cycle. The same stimulus with src1=0 and wb_dest=0 gives ex_val1=0.
- Load-use: a load to r7 in EX, then ID reads src2=7 with id_use_src2=1. hazard_stall=1 for one cycle and a bubble enters EX (ex_valid=0). Next cycle hazard_stall=0 and the instruction enters EX. With id_use_src2=0, no stall occurs.
- Flush: flush=1 with a valid ID instruction gives ex_valid=0 and all control 0 next cycle. Flush together with a hazard gives hazard_stall=0.
- Freeze: hold freeze=1 for 3 cycles while the ID inputs change and flush pulses. The ex_* outputs stay unchanged. After release, the next edge loads the current ID payload.
- Async reset mid-operation: pull rst low between clock edges while ex_valid=1. ex_valid drops to 0 without waiting for a clk edge.
